// File: rtl/dcache_pkg.sv
// Shared definitions for the L1 data cache: address split widths and controller state encoding.
package dcache_pkg;

    localparam int unsigned OFFSET_W   = 5;
    localparam int unsigned WORD_SEL_W = 3;
    localparam int unsigned WORD_W     = 32;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WRITEBACK = 2'd1;
    localparam logic [1:0] ST_ALLOCATE  = 2'd2;
    localparam logic [1:0] ST_UPDATE    = 2'd3;

    function automatic int unsigned index_w(input int unsigned lines);
        return 32'($clog2(lines));
    endfunction

    function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned lines);
        return addr_w - OFFSET_W - 32'($clog2(lines));
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag, valid, dirty and data arrays: one combinational read port, one write port
// that either fills a whole line, stores one word, or cleans the dirty bit.
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int unsigned LINES   = 32,
    parameter int unsigned TAG_W   = 22,
    parameter int unsigned BLOCK_W = 256
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [$clog2(LINES)-1:0]   index,
    output logic [TAG_W-1:0]           rd_tag,
    output logic                       rd_valid,
    output logic                       rd_dirty,
    output logic [BLOCK_W-1:0]         rd_line,
    input  logic                       fill,
    input  logic [TAG_W-1:0]           fill_tag,
    input  logic [BLOCK_W-1:0]         fill_line,
    input  logic                       store,
    input  logic [WORD_SEL_W-1:0]      store_word_sel,
    input  logic [WORD_W-1:0]          store_data,
    input  logic                       clean
);

    logic [TAG_W-1:0]   tags  [LINES];
    logic [BLOCK_W-1:0] lines [LINES];
    logic [LINES-1:0]   valid;
    logic [LINES-1:0]   dirty;

    assign rd_tag   = tags[index];
    assign rd_valid = valid[index];
    assign rd_dirty = dirty[index];
    assign rd_line  = lines[index];

    // Payload arrays carry no reset; the valid bits gate them.
    always_ff @(posedge clk_i) begin
        if (fill) begin
            tags[index]  <= fill_tag;
            lines[index] <= fill_line;
        end else if (store) begin
            lines[index][{store_word_sel, 5'b00000} +: WORD_W] <= store_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid <= '0;
            dirty <= '0;
        end else if (fill) begin
            valid[index] <= 1'b1;
            dirty[index] <= 1'b0;
        end else if (store) begin
            dirty[index] <= 1'b1;
        end else if (clean) begin
            dirty[index] <= 1'b0;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller: hit path,
// miss FSM and block-wide handshake to backing memory.
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int unsigned LINES   = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned BLOCK_W = 256
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_i,
    input  logic               write_i,
    input  logic [ADDR_W-1:0]  addr_i,
    input  logic [31:0]        data_i,
    output logic [31:0]        data_o,
    output logic               stall_o,
    output logic               mem_enable_o,
    output logic               mem_write_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic [BLOCK_W-1:0] mem_data_o,
    input  logic [BLOCK_W-1:0] mem_data_i,
    input  logic               mem_ack_i
);

    localparam int unsigned INDEX_W = index_w(LINES);
    localparam int unsigned TAG_W   = tag_w(ADDR_W, LINES);

    logic [INDEX_W-1:0]    req_index;
    logic [TAG_W-1:0]      req_tag;
    logic [WORD_SEL_W-1:0] word_sel;
    logic                  unused_addr_bits;

    assign req_index        = addr_i[OFFSET_W +: INDEX_W];
    assign req_tag          = addr_i[ADDR_W-1 -: TAG_W];
    assign word_sel         = addr_i[OFFSET_W-WORD_SEL_W +: WORD_SEL_W];
    assign unused_addr_bits = ^addr_i[1:0];

    logic [TAG_W-1:0]   rd_tag;
    logic               rd_valid;
    logic               rd_dirty;
    logic [BLOCK_W-1:0] rd_line;
    logic               fill;
    logic               store;
    logic               clean;

    dcache_sram #(
        .LINES   (LINES),
        .TAG_W   (TAG_W),
        .BLOCK_W (BLOCK_W)
    ) u_sram (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .index          (req_index),
        .rd_tag         (rd_tag),
        .rd_valid       (rd_valid),
        .rd_dirty       (rd_dirty),
        .rd_line        (rd_line),
        .fill           (fill),
        .fill_tag       (req_tag),
        .fill_line      (mem_data_i),
        .store          (store),
        .store_word_sel (word_sel),
        .store_data     (data_i),
        .clean          (clean)
    );

    state_t state;
    state_t state_d;
    logic   hit;
    logic   idle;
    logic   mem_ack;

    assign hit     = rd_valid & (rd_tag == req_tag);
    assign idle    = (state == ST_IDLE);
    assign mem_ack = mem_ack_i & mem_enable_o;

    // Pipeline-facing outputs are combinational so a hit costs zero cycles.
    assign stall_o = ~rst_i & req_i & (~hit | ~idle);
    assign data_o  = (~rst_i & req_i & ~write_i & hit & idle)
                   ? rd_line[{word_sel, 5'b00000} +: WORD_W] : 32'd0;

    logic               mem_enable_d;
    logic               mem_write_d;
    logic [ADDR_W-1:0]  mem_addr_d;
    logic [BLOCK_W-1:0] mem_data_d;

    always_comb begin
        state_d      = state;
        mem_enable_d = mem_enable_o;
        mem_write_d  = mem_write_o;
        mem_addr_d   = mem_addr_o;
        mem_data_d   = mem_data_o;
        fill         = 1'b0;
        store        = 1'b0;
        clean        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_i && !hit) begin
                    mem_enable_d = 1'b1;
                    if (rd_valid && rd_dirty) begin
                        state_d     = ST_WRITEBACK;
                        mem_write_d = 1'b1;
                        mem_addr_d  = {rd_tag, req_index, OFFSET_W'(0)};
                        mem_data_d  = rd_line;
                    end else begin
                        state_d     = ST_ALLOCATE;
                        mem_write_d = 1'b0;
                        mem_addr_d  = {req_tag, req_index, OFFSET_W'(0)};
                    end
                end else if (req_i && write_i) begin
                    store = 1'b1;
                end
            end
            ST_WRITEBACK: begin
                if (mem_ack) begin
                    clean        = 1'b1;
                    mem_enable_d = 1'b0;
                    state_d      = ST_ALLOCATE;
                end
            end
            ST_ALLOCATE: begin
                // Enable is low for one cycle after a writeback ack; re-issue as a fill.
                if (mem_ack) begin
                    fill         = 1'b1;
                    mem_enable_d = 1'b0;
                    state_d      = ST_UPDATE;
                end else if (!mem_enable_o) begin
                    mem_enable_d = 1'b1;
                    mem_write_d  = 1'b0;
                    mem_addr_d   = {req_tag, req_index, OFFSET_W'(0)};
                end
            end
            ST_UPDATE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
        end else begin
            state        <= state_d;
            mem_enable_o <= mem_enable_d;
            mem_write_o  <= mem_write_d;
            mem_addr_o   <= mem_addr_d;
            mem_data_o   <= mem_data_d;
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: directed scenarios plus random accesses checked
// against a flat word-memory model with per-index residency bookkeeping.
module tb_dcache_controller;

    localparam int unsigned LINES   = 32;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned BLOCK_W = 256;

    logic               clk = 1'b0;
    logic               rst;
    logic               req;
    logic               write;
    logic [31:0]        addr;
    logic [31:0]        wdata;
    logic [31:0]        data_o;
    logic               stall_o;
    logic               mem_enable_o;
    logic               mem_write_o;
    logic [31:0]        mem_addr_o;
    logic [255:0]       mem_data_o;
    logic [255:0]       mem_data_i;
    logic               mem_ack_i;
    logic               resp_ack;
    logic               spur_ack;
    logic [255:0]       resp_data;
    logic [255:0]       spur_data;

    always #5 clk = ~clk;

    assign mem_ack_i  = resp_ack | spur_ack;
    assign mem_data_i = resp_ack ? resp_data : spur_data;

    dcache_controller #(
        .LINES   (LINES),
        .ADDR_W  (ADDR_W),
        .BLOCK_W (BLOCK_W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .write_i      (write),
        .addr_i       (addr),
        .data_i       (wdata),
        .data_o       (data_o),
        .stall_o      (stall_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i)
    );

    int n_vec = 0;
    int n_err = 0;
    int ack_lat = 1;
    int req_cnt = 0;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [255:0] data;
    } mreq_t;

    mreq_t        log_q[$];
    logic [255:0] bk_mem [logic [26:0]];

    // Reference model: what the CPU should see, what memory should hold, and what each index holds.
    logic [31:0]  ref_mem [logic [29:0]];
    logic [255:0] exp_bk  [logic [26:0]];
    bit           mv [32];
    logic [21:0]  mt [32];
    bit           md [32];

    function automatic logic [31:0] init_word(input logic [29:0] wa);
        return ({wa, 2'b00} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [255:0] init_line(input logic [26:0] blk);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word({blk, 3'(w)});
        return l;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [29:0] wa);
        return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
    endfunction

    function automatic logic [255:0] ref_line(input logic [26:0] blk);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = ref_rd({blk, 3'(w)});
        return l;
    endfunction

    function automatic logic [255:0] bk_line(input logic [26:0] blk);
        return exp_bk.exists(blk) ? exp_bk[blk] : init_line(blk);
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Backing memory: acks ack_lat cycles after it sees a request, even if the request was abandoned.
    mreq_t        cur;
    logic [26:0]  cur_blk;
    initial begin
        resp_ack  = 1'b0;
        resp_data = '0;
        forever begin
            @(negedge clk);
            if (mem_enable_o === 1'b1) begin
                cur.wr   = mem_write_o;
                cur.addr = mem_addr_o;
                cur.data = mem_data_o;
                log_q.push_back(cur);
                req_cnt++;
                repeat (ack_lat - 1) @(negedge clk);
                cur_blk = cur.addr[31:5];
                if (cur.wr) bk_mem[cur_blk] = cur.data;
                resp_data = bk_mem.exists(cur_blk) ? bk_mem[cur_blk] : init_line(cur_blk);
                resp_ack  = 1'b1;
                @(negedge clk);
                resp_ack  = 1'b0;
            end
        end
    end

    task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input int lat, input string tag);
        logic [4:0]  idx;
        logic [21:0] tg;
        logic [26:0] vblk;
        logic [26:0] rblk;
        bit          hit;
        bit          wb;
        int          n;
        int          exp_n;
        int          exp_reqs;
        idx  = a[9:5];
        tg   = a[31:10];
        rblk = a[31:5];
        vblk = {mt[idx], idx};
        hit  = mv[idx] && (mt[idx] == tg);
        wb   = !hit && mv[idx] && md[idx];
        exp_n    = hit ? 0 : (wb ? 2*lat + 3 : lat + 2);
        exp_reqs = hit ? 0 : (wb ? 2 : 1);
        ack_lat = lat;
        log_q.delete();
        @(negedge clk);
        req = 1'b1; write = wr; addr = a; wdata = d;
        #1;
        chk({tag, ".stall_first"}, 256'(stall_o), 256'(!hit));
        n = 0;
        while (stall_o === 1'b1 && n < 500) begin
            n++;
            @(negedge clk);
        end
        chk({tag, ".stall_cycles"}, 256'(n), 256'(exp_n));
        if (!wr) chk({tag, ".load_data"}, 256'(data_o), 256'(ref_rd(a[31:2])));
        chk({tag, ".mem_reqs"}, 256'(log_q.size()), 256'(exp_reqs));
        if (wb && log_q.size() == 2) begin
            chk({tag, ".wb_cmd"}, 256'({log_q[0].wr, log_q[0].addr}), 256'({1'b1, vblk, 5'b0}));
            chk({tag, ".wb_data"}, log_q[0].data, ref_line(vblk));
        end
        if (!hit && log_q.size() == exp_reqs)
            chk({tag, ".fill_cmd"}, 256'({log_q[exp_reqs-1].wr, log_q[exp_reqs-1].addr}),
                256'({1'b0, rblk, 5'b0}));
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; write = 1'b0;
        if (!hit) begin
            if (wb) exp_bk[vblk] = ref_line(vblk);
            mv[idx] = 1'b1;
            mt[idx] = tg;
            md[idx] = 1'b0;
        end
        if (wr) begin
            ref_mem[a[31:2]] = d;
            md[idx] = 1'b1;
        end
    endtask

    task automatic model_reset();
        logic [26:0]  blk;
        logic [255:0] l;
        for (int i = 0; i < 32; i++) begin
            if (mv[i] && md[i]) begin
                blk = {mt[i], 5'(i)};
                l   = bk_line(blk);
                for (int w = 0; w < 8; w++) ref_mem[{blk, 3'(w)}] = l[w*32 +: 32];
            end
            mv[i] = 1'b0;
            md[i] = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    logic [31:0] ra;
    int          snap_cnt;
    initial begin
        rst = 1'b1; req = 1'b0; write = 1'b0; addr = '0; wdata = '0;
        spur_ack = 1'b0; spur_data = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset.stall", 256'(stall_o), 256'(0));
        chk("reset.data", 256'(data_o), 256'(0));
        chk("reset.mem_cmd", 256'({mem_enable_o, mem_write_o, mem_addr_o}), 256'(0));
        chk("reset.mem_data", mem_data_o, 256'(0));
        @(negedge clk);
        rst = 1'b0;

        // Cold miss, hit, dirty eviction, store miss then dirty eviction.
        access(1'b0, 32'h0000_0040, 32'h0, 4, "t1");
        access(1'b0, 32'h0000_0044, 32'h0, 1, "t2");
        access(1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 1, "t3st");
        access(1'b0, 32'h0000_0440, 32'h0, 2, "t3ld");
        chk("t3.wb_word1", 256'(log_q.size() > 0 ? log_q[0].data[63:32] : 32'hx), 256'(32'hDEAD_BEEF));
        access(1'b1, 32'h0000_0080, 32'h1234_5678, 3, "t4st");
        access(1'b0, 32'h0000_0480, 32'h0, 1, "t4ld");
        chk("t4.wb_word0", 256'(log_q.size() > 0 ? log_q[0].data[31:0] : 32'hx), 256'(32'h1234_5678));

        // Stray ack while idle must change nothing.
        @(negedge clk);
        spur_data = {8{$urandom}};
        spur_ack  = 1'b1;
        @(negedge clk);
        spur_ack  = 1'b0;
        #1;
        chk("t6.idle_outputs", 256'({stall_o, mem_enable_o, data_o}), 256'(0));
        access(1'b0, 32'h0000_0440, 32'h0, 1, "t6ld");

        for (int i = 0; i < 60; i++) begin
            ra = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 5)
               | (32'($urandom_range(0, 7)) << 2);
            access(1'($urandom_range(0, 1)), ra, $urandom, $urandom_range(1, 4), "rand");
        end

        // Reset during a slow fill abandons it; the late ack is ignored.
        access(1'b0, 32'h0000_0440, 32'h0, 1, "t5pre");
        ack_lat = 10;
        @(negedge clk);
        req = 1'b1; write = 1'b0; addr = 32'h0000_0040;
        repeat (3) @(negedge clk);
        #1;
        chk("t5.alloc_cmd", 256'({mem_enable_o, mem_write_o, mem_addr_o}), 256'({2'b10, 32'h0000_0040}));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("t5.after_reset", 256'({mem_enable_o, stall_o}), 256'(0));
        rst = 1'b0; req = 1'b0;
        snap_cnt = req_cnt;
        repeat (14) @(negedge clk);
        #1;
        chk("t5.late_ack", 256'({mem_enable_o, stall_o, data_o}), 256'(0));
        chk("t5.no_new_req", 256'(req_cnt), 256'(snap_cnt));
        model_reset();
        access(1'b0, 32'h0000_0040, 32'h0, 1, "t5reload");
        access(1'b0, 32'h0000_0480, 32'h0, 2, "t5post");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
